// File: rtl/vscale_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// vscale_mem_arbiter_if
//   Signal bundle between the vscale pipeline memory ports (imem/dmem), the
//   memory arbiter and the two-phase system bus.
//   master : the arbiter's view (takes port requests and bus responses,
//            drives port responses and the bus address phase)
//   slave  : the surrounding environment's view (pipeline + bus bridge)
//   Signal groups:
//     imem_*  fetch port   : req/addr in, wait/rdata/badmem_e out
//     dmem_*  data port    : en/wen/size/addr/wdata in, wait/rdata/badmem_e out
//     bus_*   system bus   : valid/addr/wen/size/wdata/abort out,
//                            ready/rdata/err in
// -----------------------------------------------------------------------------
interface vscale_mem_arbiter_if;
    // fetch port
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_wait;
    logic [31:0] imem_rdata;
    logic        imem_badmem_e;

    // data port
    logic        dmem_en;
    logic        dmem_wen;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_wait;
    logic [31:0] dmem_rdata;
    logic        dmem_badmem_e;

    // system bus
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic        bus_wen;
    logic [2:0]  bus_size;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        bus_abort;

    modport master (
        input  imem_req, imem_addr,
        output imem_wait, imem_rdata, imem_badmem_e,
        input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata,
        output dmem_wait, dmem_rdata, dmem_badmem_e,
        output bus_valid, bus_addr, bus_wen, bus_size, bus_wdata, bus_abort,
        input  bus_ready, bus_rdata, bus_err
    );

    modport slave (
        output imem_req, imem_addr,
        input  imem_wait, imem_rdata, imem_badmem_e,
        output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata,
        input  dmem_wait, dmem_rdata, dmem_badmem_e,
        input  bus_valid, bus_addr, bus_wen, bus_size, bus_wdata, bus_abort,
        output bus_ready, bus_rdata, bus_err
    );
endinterface

// File: rtl/vscale_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vscale_mem_arbiter
//   Shares one two-phase (address phase, then data phase) memory bus between
//   the pipeline's imem and dmem ports. Data accesses have fixed priority over
//   fetches. A watchdog forces an error completion of any data phase that the
//   bus does not finish within TIMEOUT_CYCLES cycles (0 disables it).
//   Ports:
//     clk    : clock, all state on posedge
//     reset  : synchronous, active-high
//     mem    : vscale_mem_arbiter_if.master (imem_*, dmem_*, bus_* groups)
//   Parameters:
//     TIMEOUT_CYCLES : data-phase cycles without bus_ready before forced error
//     CNT_W          : watchdog counter width, must hold TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module vscale_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    vscale_mem_arbiter_if.master  mem
);

    localparam logic [2:0] MEM_TYPE_LW = 3'd2;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA_I = 2'd1,
        DATA_D = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic expiry;
    logic done;
    logic accept;
    logic grant_d;
    logic grant_i;
    logic err_resp;

    // Completion, acceptance and grant. A new address phase may issue in the
    // same cycle the current data phase ends, so accept covers both cases.
    always_comb begin
        expiry   = WDOG_EN && (state != IDLE) && (cnt == CNT_LAST);
        // bus_ready is meaningless while IDLE, so done is qualified by state
        done     = (state != IDLE) && (mem.bus_ready || expiry);
        accept   = (state == IDLE) || done;
        grant_d  = accept && mem.dmem_en;
        grant_i  = accept && !mem.dmem_en && mem.imem_req;
        // a forced completion is always an error; bus_rdata is not looked at
        err_resp = (mem.bus_ready && mem.bus_err) || expiry;
    end

    // Bus address phase mux
    always_comb begin
        mem.bus_valid = 1'b0;
        mem.bus_addr  = 32'h0;
        mem.bus_wen   = 1'b0;
        mem.bus_size  = MEM_TYPE_LW;
        if (grant_d) begin
            mem.bus_valid = !reset;
            mem.bus_addr  = mem.dmem_addr;
            mem.bus_wen   = mem.dmem_wen;
            mem.bus_size  = mem.dmem_size;
        end else if (grant_i) begin
            mem.bus_valid = !reset;
            mem.bus_addr  = mem.imem_addr;
        end
        mem.bus_wdata = (state == DATA_D) ? mem.dmem_wdata : 32'h0;
        mem.bus_abort = !reset && expiry;
    end

    // Port responses; during reset both ports are held waiting
    always_comb begin
        mem.imem_rdata    = mem.bus_rdata;
        mem.dmem_rdata    = mem.bus_rdata;
        mem.imem_wait     = reset || (mem.imem_req && !((state == DATA_I) && done));
        mem.dmem_wait     = reset || ((state == DATA_D) && !done) ||
                            (mem.dmem_en && !accept);
        mem.imem_badmem_e = !reset && (state == DATA_I) && done && err_resp;
        mem.dmem_badmem_e = !reset && (state == DATA_D) && done && err_resp;
    end

    // Phase tracking and watchdog. Reset mid-phase abandons the transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (accept) begin
            cnt <= '0;
            if (grant_d) begin
                state <= DATA_D;
            end else if (grant_i) begin
                state <= DATA_I;
            end else begin
                state <= IDLE;
            end
        end else begin
            // not accepting implies a data phase is outstanding
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule
